// File: rtl/ps2_kbd_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_kbd_ctrl
//   Sits behind a PS/2 keyboard byte receiver. It turns raw Set-2 scan-code
//   bytes into single key events {ext, brk, code}. E0 marks an extended key,
//   F0 marks a key release, and E1 starts the Pause sequence. Events go into a
//   first-word fall-through FIFO, and the CPU reads them from there. A level
//   interrupt stays high while events are pending.
//
// Parameters
//   DEPTH        event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  clk cycles allowed between bytes of one prefix sequence
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   kbd_code   scan-code byte, stable while kbd_irq is high
//   kbd_irq    byte valid from receiver; one byte per rising edge
//   evt_pop    pop the head event (ignored when the FIFO is empty)
//   stat_clr   clear the sticky ovf / proto_err / bat_ok flags
//   irq_en     interrupt enable
//   evt_valid  FIFO not empty
//   evt_data   head event {ext, brk, code}, zero when empty
//   evt_count  FIFO occupancy, 0..DEPTH
//   ovf        sticky: an event was dropped because the FIFO was full
//   proto_err  sticky: sequence timeout, or 00/FF error byte seen in IDLE
//   bat_ok     sticky: AA (keyboard self-test passed) seen in IDLE
//   irq        irq_en & evt_valid
// ----------------------------------------------------------------------------
module ps2_kbd_ctrl #(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                kbd_code,
   input  logic                      kbd_irq,
   input  logic                      evt_pop,
   input  logic                      stat_clr,
   input  logic                      irq_en,
   output logic                      evt_valid,
   output logic [9:0]                evt_data,
   output logic [$clog2(DEPTH):0]    evt_count,
   output logic                      ovf,
   output logic                      proto_err,
   output logic                      bat_ok,
   output logic                      irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Byte strobe and parser state
   // ------------------------------------------------------------------------
   logic            irq_d_r;
   logic            stb_s;
   state_t          state_r;
   state_t          state_nxt_s;
   logic [2:0]      skip_r;
   logic [2:0]      skip_nxt_s;
   logic [TW-1:0]   timer_r;
   logic [TW-1:0]   timer_nxt_s;
   logic            push_s;
   logic [9:0]      push_data_s;
   logic            bat_set_s;
   logic            err_set_s;

   // ------------------------------------------------------------------------
   // FIFO storage and status
   // ------------------------------------------------------------------------
   logic [9:0]      mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic            full_s;
   logic            empty_s;
   logic            pop_s;
   logic            wr_en_s;
   logic            ovf_r;
   logic            proto_err_r;
   logic            bat_ok_r;

   // The receiver may hold kbd_irq high for several cycles. Only its rising
   // edge counts as a byte.
   assign stb_s = kbd_irq & ~irq_d_r;

   // Delay kbd_irq by one cycle so that its rising edge can be detected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d_r <= 1'b0;
      end else begin
         irq_d_r <= kbd_irq;
      end
   end

   // Parser state, Pause skip counter and inter-byte timer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         skip_r  <= 3'd0;
         timer_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         skip_r  <= skip_nxt_s;
         timer_r <= timer_nxt_s;
      end
   end

   // Next-state decode: prefix parsing, event generation and sequence timeout
   always_comb begin
      state_nxt_s = state_r;
      skip_nxt_s  = skip_r;
      timer_nxt_s = timer_r;
      push_s      = 1'b0;
      push_data_s = 10'd0;
      bat_set_s   = 1'b0;
      err_set_s   = 1'b0;

      if (stb_s) begin
         // A byte arriving in the cycle the timer would expire still wins.
         timer_nxt_s = '0;
         case (state_r)
            ST_IDLE: begin
               case (kbd_code)
                  8'hE0: state_nxt_s = ST_EXT;
                  8'hF0: state_nxt_s = ST_BRK;
                  8'hE1: begin
                     state_nxt_s = ST_SKIP;
                     skip_nxt_s  = 3'd7;
                  end
                  8'hAA: bat_set_s = 1'b1;
                  8'h00, 8'hFF: err_set_s = 1'b1;
                  8'hFA, 8'hFE: begin
                     // ACK / RESEND responses carry no key information
                     push_s = 1'b0;
                  end
                  default: begin
                     push_s      = 1'b1;
                     push_data_s = {2'b00, kbd_code};
                  end
               endcase
            end
            ST_EXT: begin
               if (kbd_code == 8'hF0) begin
                  state_nxt_s = ST_EXT_BRK;
               end else begin
                  push_s      = 1'b1;
                  push_data_s = {2'b10, kbd_code};
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_BRK: begin
               push_s      = 1'b1;
               push_data_s = {2'b01, kbd_code};
               state_nxt_s = ST_IDLE;
            end
            ST_EXT_BRK: begin
               push_s      = 1'b1;
               push_data_s = {2'b11, kbd_code};
               state_nxt_s = ST_IDLE;
            end
            ST_SKIP: begin
               // Pause sends E1 and then seven more bytes. They are folded
               // into a single extended E1 event.
               if (skip_r == 3'd1) begin
                  skip_nxt_s  = 3'd0;
                  push_s      = 1'b1;
                  push_data_s = {2'b10, 8'hE1};
                  state_nxt_s = ST_IDLE;
               end else begin
                  skip_nxt_s  = skip_r - 3'd1;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               skip_nxt_s  = 3'd0;
            end
         endcase
      end else if (state_r == ST_IDLE) begin
         timer_nxt_s = '0;
      end else if (timer_r == TIMER_LAST) begin
         // Abandon the partial sequence. Nothing is pushed.
         timer_nxt_s = '0;
         skip_nxt_s  = 3'd0;
         state_nxt_s = ST_IDLE;
         err_set_s   = 1'b1;
      end else begin
         timer_nxt_s = timer_r + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------------
   assign empty_s = (count_r == '0);
   assign full_s  = (count_r == COUNT_FULL);
   assign pop_s   = evt_pop & ~empty_s;
   // A pop in the same cycle frees the slot the push needs, even when full.
   assign wr_en_s = push_s & (~full_s | pop_s);

   // Event storage. Entries are only read while they hold valid data, so the
   // array itself needs no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= push_data_s;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Read/write pointers (wrap naturally modulo DEPTH) and occupancy counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({wr_en_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky status flags. A set in the same cycle as stat_clr keeps the flag at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r       <= 1'b0;
         proto_err_r <= 1'b0;
         bat_ok_r    <= 1'b0;
      end else begin
         ovf_r       <= (push_s & full_s & ~pop_s) | (ovf_r & ~stat_clr);
         proto_err_r <= err_set_s | (proto_err_r & ~stat_clr);
         bat_ok_r    <= bat_set_s | (bat_ok_r & ~stat_clr);
      end
   end

   assign evt_valid = ~empty_s;
   assign evt_data  = empty_s ? 10'd0 : mem_r[rd_ptr_r];
   assign evt_count = count_r;
   assign ovf       = ovf_r;
   assign proto_err = proto_err_r;
   assign bat_ok    = bat_ok_r;
   assign irq       = irq_en & ~empty_s;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;

   localparam int DEPTH = 8;
   localparam int TCYC  = 64;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    kbd_code = 8'd0;
   logic          kbd_irq = 1'b0;
   logic          evt_pop = 1'b0;
   logic          stat_clr = 1'b0;
   logic          irq_en = 1'b0;
   logic          evt_valid;
   logic [9:0]    evt_data;
   logic [CW-1:0] evt_count;
   logic          ovf;
   logic          proto_err;
   logic          bat_ok;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: key-sequence meaning expressed as flags plus an event queue
   logic [9:0] mq[$];
   bit         m_ext, m_brk, m_ovf, m_err, m_bat;
   int         m_skip;

   ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .rst_n(rst_n), .kbd_code(kbd_code), .kbd_irq(kbd_irq),
      .evt_pop(evt_pop), .stat_clr(stat_clr), .irq_en(irq_en),
      .evt_valid(evt_valid), .evt_data(evt_data), .evt_count(evt_count),
      .ovf(ovf), .proto_err(proto_err), .bat_ok(bat_ok), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic void model_clear();
      mq.delete();
      m_ext = 0; m_brk = 0; m_skip = 0;
      m_ovf = 0; m_err = 0; m_bat = 0;
   endfunction

   function automatic void model_push(input logic [9:0] e);
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
   endfunction

   // A key is: an optional E0, an optional F0, then the code. Pause is E1 followed by 7 bytes.
   function automatic void model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) model_push(10'h2E1);
      end else if (m_brk) begin
         model_push({m_ext, 1'b1, b});
         m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else begin model_push({2'b10, b}); m_ext = 0; end
      end else begin
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE1) m_skip = 7;
         else if (b == 8'hAA) m_bat = 1;
         else if (b == 8'h00 || b == 8'hFF) m_err = 1;
         else if (b == 8'hFA || b == 8'hFE) m_err = m_err;
         else model_push({2'b00, b});
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      kbd_code = b;
      kbd_irq  = 1'b1;
      repeat (hold) @(posedge clk);
      #1 kbd_irq = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      model_byte(b);
   endtask

   task automatic pop_one();
      evt_pop = 1'b1;
      @(posedge clk);
      #1 evt_pop = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic do_reset();
      rst_n = 1'b0; kbd_irq = 1'b0; evt_pop = 1'b0; stat_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      irq_en = 1'b1;
      #1;
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
      n_checks++; if (evt_data !== 10'h000) begin n_fail++; $display("FAIL reset_data got=%h exp=000", evt_data); end
      n_checks++; if (evt_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
      n_checks++; if ({ovf, proto_err, bat_ok, irq} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {ovf, proto_err, bat_ok, irq}); end
   endtask

   task automatic test_make_break();
      do_reset();
      irq_en = 1'b1;
      send_byte(8'h1C, 1, 1);
      n_checks++; if (evt_count !== CW'(1) || evt_data !== 10'h01C) begin n_fail++; $display("FAIL make_1c got=%0d/%h exp=1/01c", evt_count, evt_data); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_on got=%b exp=1", irq); end
      irq_en = 1'b0; #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_off got=%b exp=0", irq); end
      send_byte(8'hF0, 2, 1);
      send_byte(8'h1C, 1, 2);
      n_checks++; if (evt_count !== CW'(2)) begin n_fail++; $display("FAIL break_count got=%0d exp=2", evt_count); end
      while (mq.size() > 0) begin
         n_checks++; if (evt_data !== mq[0]) begin n_fail++; $display("FAIL mb_drain got=%h exp=%h", evt_data, mq[0]); end
         pop_one();
      end
      n_checks++; if (mq.size() != 0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL mb_empty got=%b exp=0", evt_valid); end
   endtask

   task automatic test_extended();
      do_reset();
      send_byte(8'hE0, 1, 1);
      send_byte(8'hF0, 1, 1);
      n_checks++; if (evt_count !== '0) begin n_fail++; $display("FAIL ext_prefix_count got=%0d exp=0", evt_count); end
      send_byte(8'h75, 1, 1);
      n_checks++; if (evt_data !== 10'h375 || evt_count !== CW'(1)) begin n_fail++; $display("FAIL ext_break got=%h exp=375", evt_data); end
      pop_one();
      send_byte(8'hE0, 1, 1);
      send_byte(8'h6B, 1, 1);
      n_checks++; if (evt_data !== 10'h26B) begin n_fail++; $display("FAIL ext_make got=%h exp=26b", evt_data); end
      pop_one();
      send_byte(8'hE1, 1, 1);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1, 1);
      n_checks++; if (evt_count !== '0) begin n_fail++; $display("FAIL pause_partial got=%0d exp=0", evt_count); end
      send_byte(8'h77, 1, 1);
      n_checks++; if (evt_count !== CW'(1) || evt_data !== 10'h2E1) begin n_fail++; $display("FAIL pause got=%0d/%h exp=1/2e1", evt_count, evt_data); end
      n_checks++; if (mq.size() != 1 || mq[0] !== 10'h2E1) begin n_fail++; $display("FAIL pause_model got=%0d exp=1", mq.size()); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 1, 1);
      n_checks++; if (evt_count !== CW'(DEPTH) || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%0d/%b exp=%0d/1", evt_count, ovf, DEPTH); end
      n_checks++; if (evt_data !== 10'h010) begin n_fail++; $display("FAIL ovf_head got=%h exp=010", evt_data); end
      stat_clr = 1'b1; @(posedge clk); #1 stat_clr = 1'b0; m_ovf = 0;
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
      // push and pop in the same cycle while full
      kbd_code = 8'h55; kbd_irq = 1'b1; evt_pop = 1'b1;
      @(posedge clk);
      #1 kbd_irq = 1'b0; evt_pop = 1'b0;
      @(posedge clk); #1;
      void'(mq.pop_front()); mq.push_back(10'h055);
      n_checks++; if (evt_count !== CW'(DEPTH) || ovf !== 1'b0) begin n_fail++; $display("FAIL full_pushpop got=%0d/%b exp=%0d/0", evt_count, ovf, DEPTH); end
      while (mq.size() > 0) begin
         n_checks++; if (evt_data !== mq[0]) begin n_fail++; $display("FAIL ovf_drain got=%h exp=%h", evt_data, mq[0]); end
         pop_one();
      end
      pop_one();
      n_checks++; if (evt_count !== '0 || evt_data !== 10'h000) begin n_fail++; $display("FAIL pop_empty got=%0d/%h exp=0/000", evt_count, evt_data); end
   endtask

   task automatic test_timeout();
      do_reset();
      // byte landing exactly in the expiry cycle is processed, no error
      send_byte(8'hE0, 1, 1);
      repeat (TCYC - 2) @(posedge clk);
      #1 send_byte(8'h6B, 1, 1);
      n_checks++; if (evt_data !== 10'h26B || proto_err !== 1'b0) begin n_fail++; $display("FAIL tmo_edge got=%h/%b exp=26b/0", evt_data, proto_err); end
      send_byte(8'hE0, 1, 1);
      repeat (TCYC + 2) @(posedge clk);
      #1 m_ext = 0; m_brk = 0; m_skip = 0; m_err = 1;
      n_checks++; if (proto_err !== 1'b1 || evt_count !== CW'(1)) begin n_fail++; $display("FAIL tmo got=%b/%0d exp=1/1", proto_err, evt_count); end
      send_byte(8'h1C, 1, 1);
      pop_one();
      n_checks++; if (evt_data !== 10'h01C || evt_count !== CW'(1)) begin n_fail++; $display("FAIL tmo_idle got=%h exp=01c", evt_data); end
   endtask

   task automatic test_idle_specials();
      do_reset();
      send_byte(8'hAA, 1, 1);
      send_byte(8'hFA, 1, 1);
      send_byte(8'h00, 1, 1);
      n_checks++; if ({bat_ok, proto_err} !== 2'b11 || evt_count !== '0) begin n_fail++; $display("FAIL specials got=%b%b/%0d exp=11/0", bat_ok, proto_err, evt_count); end
      // error byte together with stat_clr: error set wins, bat_ok clears
      kbd_code = 8'hFF; kbd_irq = 1'b1; stat_clr = 1'b1;
      @(posedge clk);
      #1 kbd_irq = 1'b0; stat_clr = 1'b0;
      @(posedge clk); #1;
      n_checks++; if ({bat_ok, proto_err} !== 2'b01) begin n_fail++; $display("FAIL clr_vs_set got=%b%b exp=01", bat_ok, proto_err); end
      send_byte(8'h1C, 4, 2);
      n_checks++; if (evt_count !== CW'(1) || evt_data !== 10'h01C) begin n_fail++; $display("FAIL long_strobe got=%0d exp=1", evt_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      irq_en = 1'b1;
      send_byte(8'hAA, 1, 1);
      send_byte(8'h1C, 1, 1);
      send_byte(8'h2C, 1, 1);
      send_byte(8'hF0, 1, 1);
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if ({evt_valid, evt_data, evt_count, ovf, proto_err, bat_ok, irq} !== '0) begin n_fail++; $display("FAIL reset_mid got=%b/%h/%0d exp=0", evt_valid, evt_data, evt_count); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 model_clear();
      send_byte(8'h1C, 1, 1);
      n_checks++; if (evt_count !== CW'(1) || evt_data !== 10'h01C) begin n_fail++; $display("FAIL reset_resume got=%0d/%h exp=1/01c", evt_count, evt_data); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 9))
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h33;
            default: b = 8'($urandom_range(0, 255));
         endcase
         irq_en = 1'($urandom_range(0, 1));
         send_byte(b, $urandom_range(1, 3), $urandom_range(1, 2));
         if ($urandom_range(0, 2) == 0) pop_one();
         if ($urandom_range(0, 15) == 0) begin
            stat_clr = 1'b1; @(posedge clk); #1 stat_clr = 1'b0;
            m_ovf = 0; m_err = 0; m_bat = 0;
         end
         n_checks++;
         if (evt_count !== CW'(mq.size()) || evt_data !== ((mq.size() > 0) ? mq[0] : 10'h000)
             || {ovf, proto_err, bat_ok} !== {m_ovf, m_err, m_bat}
             || irq !== (irq_en & (mq.size() > 0))) begin
            n_fail++;
            $display("FAIL rand_%0d got=%0d/%h/%b%b%b/%b exp=%0d/%h/%b%b%b", i, evt_count, evt_data,
                     ovf, proto_err, bat_ok, irq, mq.size(), (mq.size() > 0) ? mq[0] : 10'h000, m_ovf, m_err, m_bat);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_make_break();
      test_extended();
      test_overflow();
      test_timeout();
      test_idle_specials();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
